// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers one upstream byte message and replays it to the hash core, returning the digest.
// Optional watchdog abort in WAIT is enabled by defining HASH_FEEDER_WDOG_EN.
module hash_msg_feeder #(
    parameter int DEPTH    = 64,
    parameter int WDOG_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    input  logic        s_empty,
    output logic        M_valid,
    output logic [7:0]  message,
    output logic [63:0] counter,
    input  logic        hash_ready,
    input  logic [31:0] digest_in,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_data,
    output logic [63:0] d_len,
    output logic        d_trunc,
    output logic        d_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {COLLECT, START, STREAM, WAIT, RESULT} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [LW-1:0] len, rd_ptr, nlen;
    logic          take, store, done, trunc;
`ifdef HASH_FEEDER_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC);
    logic [WW-1:0] wd;
`endif

    always_comb begin
        take  = (state == COLLECT) && s_valid && s_ready;
        store = take && !(s_last && s_empty);
        nlen  = len + LW'(store);
        done  = take && (s_last || nlen == LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (store) mem[len[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            s_ready <= 1'b0;
            len     <= '0;
            rd_ptr  <= '0;
            trunc   <= 1'b0;
            M_valid <= 1'b0;
            message <= '0;
            counter <= '0;
            d_valid <= 1'b0;
            d_data  <= '0;
            d_len   <= '0;
            d_trunc <= 1'b0;
            d_err   <= 1'b0;
`ifdef HASH_FEEDER_WDOG_EN
            wd      <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    s_ready <= !done;
                    if (take) len <= nlen;
                    if (done) begin
                        // First byte may be the one being written this cycle, so bypass the buffer.
                        state   <= START;
                        M_valid <= 1'b1;
                        message <= (nlen == '0) ? 8'h00 : (len == '0) ? s_data : mem[0];
                        counter <= 64'(nlen);
                        trunc   <= !s_last;
                        rd_ptr  <= LW'(1);
                    end
                end
                START, STREAM: begin
`ifdef HASH_FEEDER_WDOG_EN
                    wd <= '0;
`endif
                    if (rd_ptr >= len) begin
                        state   <= WAIT;
                        M_valid <= 1'b0;
                        message <= '0;
                    end else begin
                        state   <= STREAM;
                        message <= mem[rd_ptr[AW-1:0]];
                        rd_ptr  <= rd_ptr + LW'(1);
                    end
                end
                WAIT: begin
                    if (hash_ready) begin
                        state   <= RESULT;
                        d_valid <= 1'b1;
                        d_data  <= digest_in;
                        d_len   <= counter;
                        d_trunc <= trunc;
                        d_err   <= 1'b0;
                    end
`ifdef HASH_FEEDER_WDOG_EN
                    else if (wd == WW'(WDOG_CYC - 2)) begin
                        state   <= RESULT;
                        d_valid <= 1'b1;
                        d_data  <= '0;
                        d_len   <= counter;
                        d_trunc <= trunc;
                        d_err   <= 1'b1;
                    end else begin
                        wd <= wd + WW'(1);
                    end
`endif
                end
                RESULT: begin
                    if (d_ready) begin
                        state   <= COLLECT;
                        d_valid <= 1'b0;
                        s_ready <= 1'b1;
                        len     <= '0;
                        rd_ptr  <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb_hash_msg_feeder: directed bench with a timing model of the hash core and a byte monitor.
module tb_hash_msg_feeder;
    localparam int DEPTH = 64;
    localparam int WDOG = 16;
    localparam logic [31:0] INIT = 32'h83656FD2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        s_valid = 1'b0, s_ready, s_last = 1'b0, s_empty = 1'b0;
    logic [7:0]  s_data = 8'h00, message;
    logic        M_valid, hash_ready, d_valid, d_ready = 1'b0, d_trunc, d_err;
    logic [63:0] counter, d_len;
    logic [31:0] digest_in, d_data;

    always #5 clk = ~clk;

    hash_msg_feeder #(.DEPTH(DEPTH), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_empty(s_empty), .M_valid(M_valid), .message(message),
        .counter(counter), .hash_ready(hash_ready), .digest_in(digest_in),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_len(d_len),
        .d_trunc(d_trunc), .d_err(d_err)
    );

    int checks = 0, errors = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mix(logic [31:0] a, logic [7:0] b);
        return {a[26:0], a[31:27]} ^ {24'h0, b};
    endfunction

    // Core model: digest ready counter+2 cycles after the START byte is seen.
    logic [31:0] h;
    logic        hr, busy, no_hr = 1'b0;
    logic [64:0] rem;
    always @(posedge clk) begin
        if (rst) begin
            hr <= 1'b0; busy <= 1'b0; h <= INIT; rem <= '0;
        end else if (!busy && M_valid) begin
            busy <= 1'b1;
            rem  <= {1'b0, counter} + 65'd1;
            hr   <= 1'b0;
            h    <= (counter == 64'd0) ? INIT : mix(INIT, message);
        end else if (busy) begin
            if (M_valid) h <= mix(h, message);
            if (rem == 65'd1) begin
                hr <= 1'b1; busy <= 1'b0;
            end else rem <= rem - 65'd1;
        end
    end
    assign hash_ready = hr && !no_hr;
    assign digest_in = h;

    int cyc = 0, mv_cnt = 0, first_mv = -1, last_mv = -1, dv_cyc = -1;
    logic [63:0] first_cnt = '0;
    logic [7:0]  mb [0:127];
    always @(posedge clk) begin
        if (M_valid) begin
            if (mv_cnt == 0) begin
                first_mv = cyc;
                first_cnt = counter;
            end
            if (mv_cnt < 128) mb[mv_cnt] = message;
            mv_cnt++;
            last_mv = cyc;
        end
        if (d_valid && dv_cyc < 0) dv_cyc = cyc;
        cyc++;
    end

    task automatic clear_mon;
        mv_cnt = 0; first_mv = -1; last_mv = -1; dv_cyc = -1;
    endtask

    logic [7:0] msg [0:127];

    function automatic logic [31:0] gold(int n);
        logic [31:0] g = INIT;
        for (int i = 0; i < n; i++) g = mix(g, msg[i]);
        return g;
    endfunction

    task automatic send(int n, bit last, bit empty, output int a);
        a = -1;
        for (int i = 0; i < n; i++) begin
            int k = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_data = msg[i];
            s_last = last && (i == n - 1);
            s_empty = empty;
            while (!s_ready && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (k >= 300) chk("srdy_timeout", 64'd0, 64'd1);
            a = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
    endtask

    task automatic result(logic [31:0] ed, int el, bit et, bit ee, int ec, int hold);
        int n = 0;
        while (!d_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("dv_timeout", d_valid, 1);
        chk("dv_cycle", cyc, ec);
        chk("d_data", d_data, ed);
        chk("d_len", d_len, el);
        chk("d_trunc", d_trunc, et);
        chk("d_err", d_err, ee);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_data", d_data, ed);
            chk("hold_valid", d_valid, 1);
            chk("hold_srdy", s_ready, 0);
        end
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        chk("dv_drop", d_valid, 0);
        chk("srdy_back", s_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int a, n;
        repeat (2) @(negedge clk);
        chk("rst_srdy", s_ready, 0);
        chk("rst_mvalid", M_valid, 0);
        chk("rst_counter", counter, 0);
        chk("rst_dvalid", d_valid, 0);
        chk("rst_ddata", d_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("srdy_after_rst", s_ready, 1);

        // zero-length message
        msg[0] = 8'hAA;
        clear_mon();
        send(1, 1, 1, a);
        result(INIT, 0, 0, 0, a + 4, 0);
        chk("z_mv_cnt", mv_cnt, 1);
        chk("z_counter", first_cnt, 0);
        chk("z_byte", mb[0], 0);

        // "abc"
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        clear_mon();
        send(3, 1, 0, a);
        result(gold(3), 3, 0, 0, a + 7, 0);
        chk("abc_mv_cnt", mv_cnt, 3);
        chk("abc_first", first_mv, a + 1);
        chk("abc_last", last_mv, a + 3);
        chk("abc_counter", first_cnt, 3);
        for (int i = 0; i < 3; i++) chk("abc_byte", mb[i], msg[i]);

        // 64 bytes without s_last, then a 65th byte held during a stalled result
        for (int i = 0; i < 64; i++) msg[i] = 8'(i);
        clear_mon();
        send(64, 0, 0, a);
        s_valid = 1'b1; s_data = 8'h40; s_last = 1'b1;
        result(gold(64), 64, 1, 0, a + 68, 10);
        chk("t_mv_cnt", mv_cnt, 64);
        chk("t_counter", first_cnt, 64);
        chk("t_byte63", mb[63], 8'h3F);
        a = cyc;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        clear_mon();
        msg[0] = 8'h40;
        result(gold(1), 1, 0, 0, a + 5, 0);
        chk("b65_mv_cnt", mv_cnt, 1);
        chk("b65_byte", mb[0], 8'h40);

        // reset during STREAM, then a 2-byte message
        for (int i = 0; i < 20; i++) msg[i] = 8'(i + 1);
        clear_mon();
        send(20, 1, 0, a);
        n = 0;
        while (mv_cnt < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_stream", M_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mv_drop", M_valid, 0);
        chk("rst_dv_low", d_valid, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_dv_after_rst", dv_cyc, -1);
        msg[0] = 8'h12; msg[1] = 8'h34;
        clear_mon();
        send(2, 1, 0, a);
        result(gold(2), 2, 0, 0, a + 6, 0);
        chk("two_mv_cnt", mv_cnt, 2);
        chk("two_byte1", mb[1], 8'h34);

`ifdef HASH_FEEDER_WDOG_EN
        // hash_ready suppressed: watchdog abort
        msg[0] = 8'h01; msg[1] = 8'h02; msg[2] = 8'h03;
        no_hr = 1'b1;
        clear_mon();
        send(3, 1, 0, a);
        result(32'h0, 3, 0, 1, a + 3 + WDOG, 0);
        no_hr = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
